// File: rtl/addroundkey_stage.sv
// Registered AddRoundKey stage for the AES-256 datapath. It XORs each accepted beat with its
// round key and holds the result in a 2-entry skid buffer, tagged with the round number.
module addroundkey_stage #(
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] mix_state_i,
    input  logic [127:0] shift_state_i,
    input  logic [127:0] round_key_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         flush_i,
    output logic [127:0] out_state_o,
    output logic [3:0]   out_round_o,
    output logic         out_last_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    logic [1:0]   cnt;
    logic [3:0]   rnd;
    logic [127:0] head_state, tail_state;
    logic [3:0]   head_round, tail_round;
    logic         head_last, tail_last;

    logic         is_final;
    logic [127:0] new_state;
    logic         accept;
    logic         pop;

    // The final round skips MixColumns, so its key is added to the ShiftRows output instead.
    assign is_final  = (rnd == LAST_RND);
    assign new_state = (is_final ? shift_state_i : mix_state_i) ^ round_key_i;

    assign in_ready_o  = (cnt != 2'd2);
    assign out_valid_o = (cnt != 2'd0);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i;

    assign out_state_o = head_state;
    assign out_round_o = head_round;
    assign out_last_o  = head_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rnd <= 4'd1;
        end else if (flush_i) begin
            rnd <= 4'd1;
        end else if (accept) begin
            rnd <= is_final ? 4'd1 : rnd + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= 2'd0;
        end else if (flush_i) begin
            cnt <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // The head always holds the oldest entry; the tail is only occupied when cnt == 2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_state <= '0;
            head_round <= '0;
            head_last  <= 1'b0;
        end else if (pop && cnt == 2'd2) begin
            head_state <= tail_state;
            head_round <= tail_round;
            head_last  <= tail_last;
        end else if (accept && (cnt == 2'd0 || (pop && cnt == 2'd1))) begin
            head_state <= new_state;
            head_round <= rnd;
            head_last  <= is_final;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tail_state <= '0;
            tail_round <= '0;
            tail_last  <= 1'b0;
        end else if (accept && !pop && cnt == 2'd1) begin
            tail_state <= new_state;
            tail_round <= rnd;
            tail_last  <= is_final;
        end
    end

endmodule

// File: tb/tb_addroundkey_stage.sv
// Bench for addroundkey_stage: directed scenarios with literal expectations plus a random phase,
// all checked every cycle against a queue-based reference model.
module tb_addroundkey_stage;

    localparam int NR = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] mix_state, shift_state, round_key;
    logic         in_valid, in_ready, flush;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last, out_valid, out_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    addroundkey_stage #(.NUM_ROUNDS(NR)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mix_state_i  (mix_state),
        .shift_state_i(shift_state),
        .round_key_i  (round_key),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .out_state_o  (out_state),
        .out_round_o  (out_round),
        .out_last_o   (out_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a FIFO of expected results plus a round number that wraps after NR.
    typedef struct {
        logic [127:0] s;
        int           r;
        logic         l;
    } ent_t;

    ent_t q[$];
    int   m_rnd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rnd <= 1;
        end else begin
            bit   acc, pp;
            ent_t e;
            acc = in_valid && (q.size() < 2) && !flush;
            pp  = (q.size() != 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (flush) begin
                q.delete();
                m_rnd <= 1;
            end else if (acc) begin
                e.s = ((m_rnd == NR) ? shift_state : mix_state) ^ round_key;
                e.r = m_rnd;
                e.l = (m_rnd == NR);
                q.push_back(e);
                m_rnd <= (m_rnd == NR) ? 1 : m_rnd + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
            chk("cmp_ready", {127'd0, in_ready}, {127'd0, q.size() < 2});
            if (q.size() != 0 && out_valid) begin
                chk("cmp_state", out_state, q[0].s);
                chk("cmp_round", {124'd0, out_round}, 128'(q[0].r));
                chk("cmp_last", {127'd0, out_last}, {127'd0, q[0].l});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] k1, k2, k3;

    initial begin
        rst = 1'b1;
        mix_state = '0; shift_state = '0; round_key = '0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_state", out_state, 128'd0);
        chk("rst_round", {124'd0, out_round}, 128'd0);
        chk("rst_last", {127'd0, out_last}, 128'd0);
        #10 rst = 1'b0;
        #1;
        chk("rst_ready", {127'd0, in_ready}, 128'd1);

        // single beat
        mix_state   = '0;
        shift_state = rand128();
        round_key   = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", {127'd0, out_valid}, 128'd1);
        chk("single_state", out_state, 128'h000102030405060708090a0b0c0d0e0f);
        chk("single_round", {124'd0, out_round}, 128'd1);
        chk("single_last", {127'd0, out_last}, 128'd0);
        tick();

        flush = 1'b1; tick(); flush = 1'b0;

        // final-round select over a full block plus one
        mix_state   = {16{8'hAA}};
        shift_state = {16{8'h55}};
        round_key   = '0;
        in_valid    = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("final_round", {124'd0, out_round}, (i == 15) ? 128'd1 : 128'(i));
            chk("final_state", out_state, (i == 14) ? {16{8'h55}} : {16{8'hAA}});
            chk("final_last", {127'd0, out_last}, {127'd0, i == 14});
        end
        in_valid = 1'b0;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;

        // backpressure
        k1 = rand128(); k2 = rand128(); k3 = rand128();
        mix_state = '0;
        out_ready = 1'b0;
        in_valid = 1'b1; round_key = k1;
        tick();
        chk("bp_ready1", {127'd0, in_ready}, 128'd1);
        round_key = k2;
        tick();
        chk("bp_ready2", {127'd0, in_ready}, 128'd0);
        round_key = k3;
        tick();
        tick();
        chk("bp_hold_ready", {127'd0, in_ready}, 128'd0);
        chk("bp_head1", out_state, k1);
        out_ready = 1'b1;
        tick();
        chk("bp_head2", out_state, k2);
        chk("bp_round2", {124'd0, out_round}, 128'd2);
        chk("bp_ready_back", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_head3", out_state, k3);
        chk("bp_round3", {124'd0, out_round}, 128'd3);
        tick();
        chk("bp_drained", {127'd0, out_valid}, 128'd0);

        flush = 1'b1; tick(); flush = 1'b0;

        // sustained push/pop with one entry resident
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mix_state = rand128(); round_key = rand128();
            tick();
            chk("stream_valid", {127'd0, out_valid}, 128'd1);
            chk("stream_ready", {127'd0, in_ready}, 128'd1);
            chk("stream_round", {124'd0, out_round}, 128'((i % NR) + 1));
        end
        in_valid = 1'b0;
        tick();
        flush = 1'b1; tick(); flush = 1'b0;

        // asynchronous reset mid-block with one entry buffered
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mix_state = rand128(); round_key = rand128();
            tick();
        end
        in_valid = 1'b0;
        chk("prerst_valid", {127'd0, out_valid}, 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_state", out_state, 128'd0);
        chk("midrst_round", {124'd0, out_round}, 128'd0);
        chk("midrst_last", {127'd0, out_last}, 128'd0);
        #2 rst = 1'b0;
        in_valid = 1'b1; mix_state = rand128(); round_key = rand128();
        tick();
        in_valid = 1'b0;
        chk("postrst_round", {124'd0, out_round}, 128'd1);
        tick();

        // flush while full and offering a beat
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        chk("fl_full", {127'd0, in_ready}, 128'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", {127'd0, out_valid}, 128'd0);
        chk("fl_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        mix_state = rand128(); round_key = rand128();
        tick();
        in_valid = 1'b0;
        chk("fl_round", {124'd0, out_round}, 128'd1);
        tick();

        // random traffic; data held while a beat is stalled
        for (int i = 0; i < 600; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid    = ($urandom_range(0, 9) < 7);
                mix_state   = rand128();
                shift_state = rand128();
                round_key   = rand128();
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
